// File: rtl/shifter_pkg.sv
// Shared shifter constants: operation encodings, data and shift-amount widths,
// and the bit-reversal helper used to run left shifts through the right network.
package shifter_pkg;

    localparam int SHIFTER_DATA_W  = 32;
    localparam int SHIFTER_SHAMT_W = 5;

    typedef enum logic [1:0] {
        SHIFTER_OPERATION_LOGICAL_SHIFT_LEFT    = 2'b00,
        SHIFTER_OPERATION_LOGICAL_SHIFT_RIGHT   = 2'b01,
        SHIFTER_OPERATION_ARITHMETIC_SHIFT_RIGHT = 2'b10,
        SHIFTER_OPERATION_RESERVED              = 2'b11
    } shifter_op_e;

    // Mirror a data word end-for-end (bit 0 <-> bit 31).
    function automatic logic [SHIFTER_DATA_W-1:0] shifter_bit_reverse(
        input logic [SHIFTER_DATA_W-1:0] value
    );
        logic [SHIFTER_DATA_W-1:0] reversed;
        for (int i = 0; i < SHIFTER_DATA_W; i++) begin
            reversed[i] = value[SHIFTER_DATA_W-1-i];
        end
        return reversed;
    endfunction

endpackage

// File: rtl/shifter_right_stage.sv
// One log stage of the right-shift network: conditionally shifts right by
// 2**SHIFT_LOG2, filling the vacated high bits with i_fill.
module shifter_right_stage #(
    parameter int DATA_W     = 32,
    parameter int SHIFT_LOG2 = 0
) (
    input  logic              i_enable,
    input  logic              i_fill,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    localparam int SHIFT = 1 << SHIFT_LOG2;

    logic [DATA_W-1:0] w_shifted;

    assign w_shifted = {{SHIFT{i_fill}}, i_data[DATA_W-1:SHIFT]};
    assign o_data    = i_enable ? w_shifted : i_data;

endmodule

// File: rtl/shifter.sv
// 32-bit barrel shifter with a single registered output. Left shifts reuse the
// right-shift network by bit-reversing the operand going in and the result
// coming out; the fill bit distinguishes logical from arithmetic right shifts.
module shifter
    import shifter_pkg::*;
(
    input  logic                       clock,
    input  logic                       resetN,
    input  logic [1:0]                 operation,
    input  logic [SHIFTER_DATA_W-1:0]  leftOperand,
    input  logic [SHIFTER_SHAMT_W-1:0] rightOperand,
    output logic [SHIFTER_DATA_W-1:0]  result
);

    shifter_op_e                     w_op;
    logic                            w_is_left;
    logic                            w_is_sar;
    logic                            w_is_reserved;
    logic signed [SHIFTER_DATA_W-1:0] w_operand_s;
    logic                            w_fill;
    logic [SHIFTER_DATA_W-1:0]       w_stage [0:SHIFTER_SHAMT_W];
    logic [SHIFTER_DATA_W-1:0]       w_shifted;
    logic [SHIFTER_DATA_W-1:0]       w_next;
    logic [SHIFTER_DATA_W-1:0]       r_result_p0;

    // Operation decode
    assign w_op          = shifter_op_e'(operation);
    assign w_is_left     = (w_op == SHIFTER_OPERATION_LOGICAL_SHIFT_LEFT);
    assign w_is_sar      = (w_op == SHIFTER_OPERATION_ARITHMETIC_SHIFT_RIGHT);
    assign w_is_reserved = (w_op == SHIFTER_OPERATION_RESERVED);

    // Sign bit only feeds the fill for arithmetic shifts; logical fill is zero.
    // A left shift runs as a right shift of the reversed word, so its fill is
    // zero too and lands in the low bits after the output reversal.
    assign w_operand_s = leftOperand;
    assign w_fill      = w_is_sar & w_operand_s[SHIFTER_DATA_W-1];

    assign w_stage[0] = w_is_left ? shifter_bit_reverse(leftOperand) : leftOperand;

    genvar k;
    generate
        for (k = 0; k < SHIFTER_SHAMT_W; k++) begin : g_stage
            shifter_right_stage #(
                .DATA_W    (SHIFTER_DATA_W),
                .SHIFT_LOG2(k)
            ) u_stage (
                .i_enable (rightOperand[k]),
                .i_fill   (w_fill),
                .i_data   (w_stage[k]),
                .o_data   (w_stage[k+1])
            );
        end
    endgenerate

    assign w_shifted = w_is_left ? shifter_bit_reverse(w_stage[SHIFTER_SHAMT_W])
                                 : w_stage[SHIFTER_SHAMT_W];

    // Reserved code forces a clean zero rather than whatever the network produced.
    assign w_next = w_is_reserved ? '0 : w_shifted;

    // Result register: loads every edge, synchronous active-low clear has priority.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_result_p0 <= '0;
        end else begin
            r_result_p0 <= w_next;
        end
    end

    assign result = r_result_p0;

endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for the shifter: directed vectors from the shift rules,
// then a randomized back-to-back stream with occasional resets, all checked
// against a plain-operator reference model.
module tb_shifter;

    logic        clock;
    logic        resetN;
    logic [1:0]  operation;
    logic [31:0] leftOperand;
    logic [4:0]  rightOperand;
    logic [31:0] result;

    int n_checks;
    int n_fail;

    shifter dut (
        .clock        (clock),
        .resetN       (resetN),
        .operation    (operation),
        .leftOperand  (leftOperand),
        .rightOperand (rightOperand),
        .result       (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the shift rules written with the language's own operators.
    function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [4:0] s);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return sa >>> s;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one operation at a falling edge and check it one rising edge later.
    task automatic run_vec(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [4:0] s,
                           input logic [31:0] exp);
        operation    = op;
        leftOperand  = a;
        rightOperand = s;
        @(negedge clock);
        check(tag, result, exp);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [4:0]  r_s;
        logic        r_rst_n;
        logic [31:0] exp;

        n_checks     = 0;
        n_fail       = 0;
        resetN       = 1'b0;
        operation    = 2'b00;
        leftOperand  = 32'hffff_ffff;
        rightOperand = 5'd3;

        // Reset held for two edges with non-zero operands
        @(negedge clock);
        check("reset_edge1", result, 32'h0000_0000);
        operation   = 2'b10;
        leftOperand = 32'h8000_0000;
        @(negedge clock);
        check("reset_edge2", result, 32'h0000_0000);

        // Release edge loads a normal result
        resetN = 1'b1;
        run_vec("reset_release", 2'b00, 32'h0000_0003, 5'd4, 32'h0000_0030);

        run_vec("sll_17",  2'b00, 32'h0472b8af, 5'd17, 32'h715e0000);
        run_vec("sll_1",   2'b00, 32'h01234567, 5'd1,  32'h02468ace);
        run_vec("sll_31",  2'b00, 32'h00000001, 5'd31, 32'h80000000);
        run_vec("slr_17",  2'b01, 32'h0472b8af, 5'd17, 32'h00000239);
        run_vec("slr_1a",  2'b01, 32'h22222222, 5'd1,  32'h11111111);
        run_vec("slr_1b",  2'b01, 32'h80000000, 5'd1,  32'h40000000);
        run_vec("sar_17",  2'b10, 32'h0472b8af, 5'd17, 32'h00000239);
        run_vec("sar_1a",  2'b10, 32'h22222222, 5'd1,  32'h11111111);
        run_vec("sar_1b",  2'b10, 32'h80000000, 5'd1,  32'hc0000000);
        run_vec("sar_31n", 2'b10, 32'h80000000, 5'd31, 32'hffffffff);
        run_vec("sar_31p", 2'b10, 32'h7fffffff, 5'd31, 32'h00000000);
        run_vec("sll_0",   2'b00, 32'hdeadbeef, 5'd0,  32'hdeadbeef);
        run_vec("slr_0",   2'b01, 32'hdeadbeef, 5'd0,  32'hdeadbeef);
        run_vec("sar_0",   2'b10, 32'hdeadbeef, 5'd0,  32'hdeadbeef);
        run_vec("rsv",     2'b11, 32'hdeadbeef, 5'd7,  32'h00000000);
        run_vec("rsv_0",   2'b11, 32'hffffffff, 5'd0,  32'h00000000);

        // Randomized stream: new inputs every cycle, occasional reset pulses,
        // and input scrambling between edges that must not reach the output.
        for (int i = 0; i < 400; i++) begin
            r_op    = 2'($urandom_range(0, 3));
            r_a     = $urandom;
            r_s     = 5'($urandom_range(0, 31));
            r_rst_n = ($urandom_range(0, 15) != 0);
            exp     = r_rst_n ? ref_shift(r_op, r_a, r_s) : 32'h0000_0000;
            resetN       = r_rst_n;
            operation    = r_op;
            leftOperand  = r_a;
            rightOperand = r_s;
            @(posedge clock);
            #1;
            if (i % 3 == 0) begin
                operation    = 2'($urandom_range(0, 3));
                leftOperand  = $urandom;
                rightOperand = 5'($urandom_range(0, 31));
                resetN       = 1'b1;
            end
            @(negedge clock);
            check(r_rst_n ? "rand" : "rand_reset", result, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
